// File: rtl/spi_master_tx16.sv
// SPI mode-0 master: one 16-bit frame per start, MSB first, SS held low across both bytes.
// Shifts in miso at the same time, so the frame also returns a 16-bit rx word.
module spi_master_tx16 #(
  parameter int HALF_PERIOD = 50,
  parameter int GAP_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        SS
);

  localparam int TW = $clog2(HALF_PERIOD + GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_HALF = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(HALF_PERIOD + GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCLK_LO,
    SCLK_HI,
    HOLD,
    RECOVER
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic [15:0]   tx_sh, tx_sh_d;
  logic [15:0]   rx_sh, rx_sh_d;
  logic [15:0]   rx_data_d;
  logic          busy_d, done_d, sclk_d, mosi_d, ss_d;
  logic          miso_s1, miso_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tmr     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      SS      <= 1'b1;
    end else begin
      state   <= state_d;
      tmr     <= tmr_d;
      bit_cnt <= bit_cnt_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
      rx_data <= rx_data_d;
      busy    <= busy_d;
      done    <= done_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
      SS      <= ss_d;
    end
  end

  always_comb begin
    state_d   = state;
    tmr_d     = (tmr != '0) ? tmr - TW'(1) : tmr;
    bit_cnt_d = bit_cnt;
    tx_sh_d   = tx_sh;
    rx_sh_d   = rx_sh;
    rx_data_d = rx_data;
    busy_d    = busy;
    done_d    = 1'b0;
    sclk_d    = sclk;
    mosi_d    = mosi;
    ss_d      = SS;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d   = SCLK_LO;
          tmr_d     = T_HALF;
          tx_sh_d   = tx_data;
          bit_cnt_d = '0;
          rx_sh_d   = '0;
          busy_d    = 1'b1;
          ss_d      = 1'b0;
          mosi_d    = tx_data[15];
        end
      end
      SCLK_LO: begin
        if (tmr == '0) begin
          state_d = SCLK_HI;
          tmr_d   = T_HALF;
          sclk_d  = 1'b1;
        end
      end
      SCLK_HI: begin
        if (tmr == '0) begin
          rx_sh_d = {rx_sh[14:0], miso_s2};
          sclk_d  = 1'b0;
          if (bit_cnt == 4'd15) begin
            state_d = HOLD;
            tmr_d   = T_HALF;
          end else begin
            state_d   = SCLK_LO;
            bit_cnt_d = bit_cnt + 4'd1;
            // the low phase before byte 1 is stretched by the inter-byte gap
            tmr_d     = (bit_cnt == 4'd7) ? T_GAP : T_HALF;
            mosi_d    = tx_sh[4'd14 - bit_cnt];
          end
        end
      end
      HOLD: begin
        if (tmr == '0) begin
          state_d = RECOVER;
          tmr_d   = T_HALF;
          ss_d    = 1'b1;
          mosi_d  = 1'b0;
        end
      end
      RECOVER: begin
        if (tmr == '0) begin
          state_d   = IDLE;
          rx_data_d = rx_sh;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_tx16.sv
// Bench for spi_master_tx16: random frames checked against a frame-level model
// (word on sclk rises, SS-low length, start-to-done latency, rx word).
module tb_spi_master_tx16;

  localparam int HP  = 4;
  localparam int GAP = 8;
  localparam int LAT = 34 * HP + GAP + 1;
  localparam int SSL = 33 * HP + GAP;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] tx_data;
  logic        busy, done, sclk, mosi, SS;
  logic [15:0] rx_data;
  logic        miso;
  logic        loop_en = 1'b0;
  logic        miso_fix = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  assign miso = loop_en ? mosi : miso_fix;

  spi_master_tx16 #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .SS(SS)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          edges = 0;
  int          ssl = 0;
  int          dones = 0;
  int          done_cyc = 0;
  logic        busy_done = 1'b0;
  logic        sclk_p = 1'b0;
  logic [15:0] cap = '0;

  always @(negedge clk) begin
    if (sclk && !sclk_p && !SS) begin
      edges = edges + 1;
      cap = {cap[14:0], mosi};
    end
    sclk_p = sclk;
    if (!SS) ssl = ssl + 1;
    if (done) begin
      dones = dones + 1;
      done_cyc = cyc;
      busy_done = busy;
    end
  end

  logic [15:0] exp_rx = '0;

  // Caller must be at negedge+1 with busy low; returns at negedge+1 of the done cycle.
  task automatic run_frame(input logic [15:0] d, input bit tog,
                           output int lat, output int ne, output logic [15:0] w,
                           output int ns, output logic bd, output bit to);
    int e0, s0, d0, t0;
    e0 = edges; s0 = ssl; d0 = dones;
    tx_data = d;
    start = 1'b1;
    t0 = cyc;
    to = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (dones != d0) begin
        to = 1'b0;
        break;
      end
      if (tog) tx_data = 16'($urandom);
      @(negedge clk); #1;
    end
    lat = done_cyc - t0;
    ne = edges - e0;
    w = cap;
    ns = ssl - s0;
    bd = busy_done;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (SS !== 1'b1) begin n_err++; $display("FAIL reset_ss got %b want 1", SS); end
    n_cmp++; if (sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk got %b want 0", sclk); end
    n_cmp++; if (mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi got %b want 0", mosi); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (rx_data !== 16'h0) begin n_err++; $display("FAIL reset_rx got %h want 0000", rx_data); end
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_frame_a53c;
    int lat, ne, ns; logic [15:0] w; logic bd; bit to;
    loop_en = 1'b0; miso_fix = 1'b0;
    run_frame(16'hA53C, 1'b0, lat, ne, w, ns, bd, to);
    exp_rx = 16'h0000;
    n_cmp++; if (to) begin n_err++; $display("FAIL a53c_timeout got no done want done"); end
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL a53c_latency got %0d want %0d", lat, LAT); end
    n_cmp++; if (ne !== 16) begin n_err++; $display("FAIL a53c_edges got %0d want 16", ne); end
    n_cmp++; if (w !== 16'hA53C) begin n_err++; $display("FAIL a53c_word got %h want a53c", w); end
    n_cmp++; if (ns !== SSL) begin n_err++; $display("FAIL a53c_ss_low got %0d want %0d", ns, SSL); end
    n_cmp++; if (rx_data !== exp_rx) begin n_err++; $display("FAIL a53c_rx got %h want %h", rx_data, exp_rx); end
  endtask

  task automatic test_reset_mid;
    int e0, d0, lat, ne, ns; logic [15:0] w, d; logic bd; bit to, hit;
    e0 = edges; d0 = dones; hit = 1'b0;
    loop_en = 1'b1;
    tx_data = 16'($urandom);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (edges - e0 == 7) begin hit = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL rstmid_7th_edge got %0d edges want 7", edges - e0); end
    reset = 1'b1;
    #1;
    n_cmp++; if (SS !== 1'b1) begin n_err++; $display("FAIL rstmid_ss got %b want 1", SS); end
    n_cmp++; if (sclk !== 1'b0) begin n_err++; $display("FAIL rstmid_sclk got %b want 0", sclk); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (mosi !== 1'b0) begin n_err++; $display("FAIL rstmid_mosi got %b want 0", mosi); end
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (dones !== d0) begin n_err++; $display("FAIL rstmid_no_done got %0d want %0d", dones, d0); end
    n_cmp++; if (rx_data !== exp_rx) begin n_err++; $display("FAIL rstmid_rx_hold got %h want %h", rx_data, exp_rx); end
    d = 16'($urandom);
    run_frame(d, 1'b0, lat, ne, w, ns, bd, to);
    exp_rx = d;
    n_cmp++; if (to || lat !== LAT) begin n_err++; $display("FAIL rstmid_clean_latency got %0d want %0d", lat, LAT); end
    n_cmp++; if (ne !== 16 || w !== d) begin n_err++; $display("FAIL rstmid_clean_word got %h/%0d want %h/16", w, ne, d); end
    n_cmp++; if (rx_data !== exp_rx) begin n_err++; $display("FAIL rstmid_clean_rx got %h want %h", rx_data, exp_rx); end
  endtask

  task automatic test_loopback;
    int lat, ne, ns; logic [15:0] w, d; logic bd; bit to;
    loop_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = (k == 0) ? 16'h5AF0 : 16'($urandom);
      run_frame(d, 1'b0, lat, ne, w, ns, bd, to);
      exp_rx = d;
      n_cmp++; if (to || lat !== LAT) begin n_err++; $display("FAIL loop_latency[%0d] got %0d want %0d", k, lat, LAT); end
      n_cmp++; if (w !== d) begin n_err++; $display("FAIL loop_word[%0d] got %h want %h", k, w, d); end
      n_cmp++; if (rx_data !== exp_rx) begin n_err++; $display("FAIL loop_rx[%0d] got %h want %h", k, rx_data, exp_rx); end
      n_cmp++; if (bd !== 1'b0) begin n_err++; $display("FAIL loop_busy_at_done[%0d] got %b want 0", k, bd); end
      n_cmp++; if (ns !== SSL) begin n_err++; $display("FAIL loop_ss_low[%0d] got %0d want %0d", k, ns, SSL); end
    end
  endtask

  task automatic test_miso_high;
    int lat, ne, ns; logic [15:0] w; logic bd; bit to;
    loop_en = 1'b0; miso_fix = 1'b1;
    run_frame(16'($urandom), 1'b0, lat, ne, w, ns, bd, to);
    exp_rx = 16'hFFFF;
    n_cmp++; if (to || rx_data !== exp_rx) begin n_err++; $display("FAIL miso_high_rx got %h want %h", rx_data, exp_rx); end
    miso_fix = 1'b0;
  endtask

  task automatic test_start_flood;
    int e0, d0, t0; logic pb; int q[$]; logic [15:0] d; bit to;
    int exp_rise[3];
    exp_rise[0] = 1; exp_rise[1] = LAT + 1; exp_rise[2] = 2 * LAT + 1;
    loop_en = 1'b1;
    e0 = edges; d0 = dones;
    d = 16'($urandom);
    tx_data = d;
    start = 1'b1;
    t0 = cyc;
    pb = busy;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (busy && !pb) q.push_back(cyc - t0);
      pb = busy;
    end
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!busy) begin to = 1'b0; break; end
      @(negedge clk); #1;
    end
    exp_rx = d;
    n_cmp++; if (to) begin n_err++; $display("FAIL flood_timeout got busy want idle"); end
    n_cmp++; if (q.size() !== 3) begin n_err++; $display("FAIL flood_accepts got %0d want 3", q.size()); end
    for (int k = 0; k < 3 && k < q.size(); k++) begin
      n_cmp++;
      if (q[k] !== exp_rise[k]) begin n_err++; $display("FAIL flood_busy_rise[%0d] got %0d want %0d", k, q[k], exp_rise[k]); end
    end
    n_cmp++; if (edges - e0 !== 48) begin n_err++; $display("FAIL flood_edges got %0d want 48", edges - e0); end
    n_cmp++; if (dones - d0 !== 3) begin n_err++; $display("FAIL flood_dones got %0d want 3", dones - d0); end
    n_cmp++; if (rx_data !== exp_rx) begin n_err++; $display("FAIL flood_rx got %h want %h", rx_data, exp_rx); end
  endtask

  task automatic test_back_to_back;
    int lat, ne, ns; logic [15:0] w; logic bd; bit to;
    logic [15:0] words[2];
    words[0] = 16'hFFFF; words[1] = 16'h0000;
    loop_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_frame(words[k], 1'b1, lat, ne, w, ns, bd, to);
      exp_rx = words[k];
      n_cmp++; if (to || lat !== LAT) begin n_err++; $display("FAIL b2b_latency[%0d] got %0d want %0d", k, lat, LAT); end
      n_cmp++; if (ne !== 16 || w !== words[k]) begin n_err++; $display("FAIL b2b_word[%0d] got %h/%0d want %h/16", k, w, ne, words[k]); end
      n_cmp++; if (rx_data !== exp_rx) begin n_err++; $display("FAIL b2b_rx[%0d] got %h want %h", k, rx_data, exp_rx); end
    end
    tx_data = '0;
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || SS !== 1'b1) begin n_err++; $display("FAIL b2b_idle got busy=%b ss=%b want 0/1", busy, SS); end
  endtask

  initial begin
    test_reset;
    test_frame_a53c;
    test_reset_mid;
    test_loopback;
    test_miso_high;
    test_start_flood;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
